// File: rtl/core_ahb_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_ahb_master: arbitrates IF fetch and MEM data ports onto one AHB-Lite |
// | master port. Optional macro CORE_AHB_ERR_EN: error reporting + err_addr.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module core_ahb_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
`ifdef CORE_AHB_ERR_EN
  output logic [ADDR_W-1:0] err_addr,
`endif
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0] C_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] C_TRANS_NONSEQ = 2'b10;
  localparam logic [3:0] C_PROT_FETCH   = 4'b0010;
  localparam logic [3:0] C_PROT_DATA    = 4'b0011;
  localparam logic [2:0] C_SIZE_WORD    = 3'b010;
  localparam logic       C_GNT_I        = 1'b0;
  localparam logic       C_GNT_D        = 1'b1;

  state_t            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [3:0]        hprot_q, hprot_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
`ifdef CORE_AHB_ERR_EN
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
`else
  logic              unused_hresp;
  assign unused_hresp = HRESP;
`endif

  logic              gnt_data;
  logic [1:0]        eff_size;
  logic [DATA_W-1:0] lane_wdata;

  // Size 11 behaves as a word; store data is replicated across byte lanes.
  always_comb begin
    eff_size = (d_size == 2'b11) ? 2'b10 : d_size;
    case (eff_size)
      2'b00:   lane_wdata = {4{d_wdata[7:0]}};
      2'b01:   lane_wdata = {2{d_wdata[15:0]}};
      default: lane_wdata = d_wdata;
    endcase
    gnt_data = d_req && (!i_req || (last_gnt_q == C_GNT_I));
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hprot_d    = hprot_q;
    wdata_d    = wdata_q;
    hwdata_d   = hwdata_q;
    rdata_d    = rdata_q;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
`ifdef CORE_AHB_ERR_EN
    err_d      = err_q;
    err_addr_d = err_addr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          owner_d  = gnt_data;
          htrans_d = C_TRANS_NONSEQ;
          if (gnt_data) begin
            haddr_d  = d_addr;
            hwrite_d = d_we;
            hsize_d  = {1'b0, eff_size};
            hprot_d  = C_PROT_DATA;
            wdata_d  = lane_wdata;
          end else begin
            haddr_d  = i_addr;
            hwrite_d = 1'b0;
            hsize_d  = C_SIZE_WORD;
            hprot_d  = C_PROT_FETCH;
          end
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          htrans_d = C_TRANS_IDLE;
          if (hwrite_q) hwdata_d = wdata_q;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // First cycle of a two-cycle ERROR has HREADY low and is just a wait.
        if (HREADY) begin
          rdata_d = HRDATA;
          i_ack_d = (owner_q == C_GNT_I);
          d_ack_d = (owner_q == C_GNT_D);
`ifdef CORE_AHB_ERR_EN
          err_d = HRESP;
          if (HRESP) err_addr_d = haddr_q;
`endif
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        last_gnt_d = owner_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= C_GNT_I;
      owner_q    <= C_GNT_I;
      haddr_q    <= '0;
      htrans_q   <= C_TRANS_IDLE;
      hwrite_q   <= 1'b0;
      hsize_q    <= C_SIZE_WORD;
      hprot_q    <= C_PROT_DATA;
      wdata_q    <= '0;
      hwdata_q   <= '0;
      rdata_q    <= '0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
`ifdef CORE_AHB_ERR_EN
      err_q      <= 1'b0;
      err_addr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      hprot_q    <= hprot_d;
      wdata_q    <= wdata_d;
      hwdata_q   <= hwdata_d;
      rdata_q    <= rdata_d;
      i_ack_q    <= i_ack_d;
      d_ack_q    <= d_ack_d;
`ifdef CORE_AHB_ERR_EN
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
`endif
    end
  end

  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = 3'b000;
  assign HPROT     = hprot_q;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = hwdata_q;

  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = rdata_q;
  assign d_rdata = rdata_q;
`ifdef CORE_AHB_ERR_EN
  assign i_err    = err_q & i_ack_q;
  assign d_err    = err_q & d_ack_q;
  assign err_addr = err_addr_q;
`else
  assign i_err = 1'b0;
  assign d_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_ahb_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_core_ahb_master: directed and randomized bench for core_ahb_master.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_core_ahb_master;

`ifdef CORE_AHB_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_ack, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_size;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
`ifdef CORE_AHB_ERR_EN
  logic [31:0] err_addr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  core_ahb_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
`ifdef CORE_AHB_ERR_EN
    .err_addr(err_addr),
`endif
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_size = 2'b10;
    HRDATA = 0; HREADY = 1; HRESP = 0;
  endtask

  // Expected store lane pattern, computed arithmetically.
  function automatic logic [31:0] lanes(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'b00:   return {24'h0, w[7:0]} * 32'h0101_0101;
      2'b01:   return {16'h0, w[15:0]} * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  task automatic test_reset();
    logic [77:0] exp_ahb, got_ahb;
    logic [67:0] got_port;
    reset = 1;
    idle_inputs();
    step(); step();
    exp_ahb = {32'h0, 2'b00, 1'b0, 3'b010, 3'b000, 4'b0011, 1'b0, 32'h0};
    got_ahb = {HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA};
    n_checks++;
    if (got_ahb !== exp_ahb) begin
      n_fail++; $display("FAIL reset_ahb: got %h expected %h", got_ahb, exp_ahb);
    end
    got_port = {i_ack, d_ack, i_err, d_err, i_rdata, d_rdata};
    n_checks++;
    if (got_port !== 68'h0) begin
      n_fail++; $display("FAIL reset_ports: got %h expected 0", got_port);
    end
`ifdef CORE_AHB_ERR_EN
    n_checks++;
    if (err_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_err_addr: got %h expected 0", err_addr);
    end
`endif
    reset = 0;
  endtask

  task automatic test_fetch();
    i_req = 1; i_addr = 32'h100; HRDATA = 32'h0050_0093; HREADY = 1;
    step();
    n_checks++;
    if ({HTRANS, HADDR, HPROT, HSIZE, HWRITE} !== {2'b10, 32'h100, 4'b0010, 3'b010, 1'b0}) begin
      n_fail++; $display("FAIL fetch_nonseq: got trans=%b addr=%h prot=%b size=%b wr=%b expected 10/100/0010/010/0",
                         HTRANS, HADDR, HPROT, HSIZE, HWRITE);
    end
    step();
    n_checks++;
    if ({HTRANS, i_ack} !== 3'b000) begin
      n_fail++; $display("FAIL fetch_dataphase: got trans=%b ack=%b expected 00/0", HTRANS, i_ack);
    end
    step();
    HRDATA = 32'hDEAD_BEEF;
    n_checks++;
    if ({i_ack, d_ack, i_err, i_rdata} !== {3'b100, 32'h0050_0093}) begin
      n_fail++; $display("FAIL fetch_ack: got ack=%b dack=%b err=%b rdata=%h expected 1/0/0/00500093",
                         i_ack, d_ack, i_err, i_rdata);
    end
    i_req = 0;
    step();
    n_checks++;
    if (i_ack !== 1'b0) begin
      n_fail++; $display("FAIL fetch_ack_pulse: got %b expected 0", i_ack);
    end
  endtask

  task automatic test_byte_store();
    d_req = 1; d_we = 1; d_addr = 32'h2003; d_size = 2'b00; d_wdata = 32'hAB; HREADY = 1;
    step();
    n_checks++;
    if ({HTRANS, HADDR, HSIZE, HWRITE, HPROT} !== {2'b10, 32'h2003, 3'b000, 1'b1, 4'b0011}) begin
      n_fail++; $display("FAIL store_nonseq: got trans=%b addr=%h size=%b wr=%b prot=%b", HTRANS, HADDR, HSIZE, HWRITE, HPROT);
    end
    step();
    HREADY = 0;
    n_checks++;
    if ({HTRANS, HWDATA} !== {2'b00, 32'hABAB_ABAB}) begin
      n_fail++; $display("FAIL store_hwdata: got trans=%b hwdata=%h expected 00/ABABABAB", HTRANS, HWDATA);
    end
    step();
    HREADY = 0;
    step();
    HREADY = 1;
    n_checks++;
    if (d_ack !== 1'b0 || HWDATA !== 32'hABAB_ABAB) begin
      n_fail++; $display("FAIL store_wait: got ack=%b hwdata=%h expected 0/ABABABAB", d_ack, HWDATA);
    end
    step();
    n_checks++;
    if ({d_ack, i_ack} !== 2'b10) begin
      n_fail++; $display("FAIL store_ack_c5: got d_ack=%b i_ack=%b expected 1/0", d_ack, i_ack);
    end
    d_req = 0; d_we = 0;
    step();
    n_checks++;
    if (d_ack !== 1'b0) begin
      n_fail++; $display("FAIL store_ack_pulse: got %b expected 0", d_ack);
    end
  endtask

  task automatic test_contention();
    logic [31:0] hr [0:16];
    logic [1:0]  exp_ack;
    int          acks = 0;
    bit          next_d = 1;
    reset = 1;
    idle_inputs();
    i_req = 1; i_addr = 32'h200;
    d_req = 1; d_we = 0; d_addr = 32'h3000; d_size = 2'b10;
    step(); step();
    reset = 0;
    hr[0] = $urandom; HRDATA = hr[0];
    for (int c = 1; c <= 16; c++) begin
      step();
      exp_ack = 2'b00;
      if (c % 4 == 3) begin
        exp_ack = next_d ? 2'b01 : 2'b10;
        next_d  = !next_d;
      end
      n_checks++;
      if ({i_ack, d_ack} !== exp_ack) begin
        n_fail++; $display("FAIL contention_c%0d: got i/d ack=%b%b expected %b", c, i_ack, d_ack, exp_ack);
      end
      if (exp_ack != 2'b00) begin
        acks++;
        n_checks++;
        if ((exp_ack[0] ? d_rdata : i_rdata) !== hr[c-1]) begin
          n_fail++; $display("FAIL contention_rdata_c%0d: got %h expected %h", c, exp_ack[0] ? d_rdata : i_rdata, hr[c-1]);
        end
      end
      hr[c] = $urandom; HRDATA = hr[c];
    end
    i_req = 0; d_req = 0;
    step();
    n_checks++;
    if (acks != 4 || HTRANS !== 2'b00) begin
      n_fail++; $display("FAIL contention_end: got acks=%0d trans=%b expected 4/00", acks, HTRANS);
    end
  endtask

  task automatic test_error();
    d_req = 1; d_we = 0; d_addr = 32'h4000; d_size = 2'b10; HREADY = 1; HRESP = 0;
    step();
    n_checks++;
    if ({HTRANS, HADDR} !== {2'b10, 32'h4000}) begin
      n_fail++; $display("FAIL err_nonseq: got trans=%b addr=%h", HTRANS, HADDR);
    end
    step();
    HREADY = 0; HRESP = 1;
    step();
    HREADY = 1; HRESP = 1; HRDATA = 32'h55;
    n_checks++;
    if ({HTRANS, d_ack} !== 3'b000) begin
      n_fail++; $display("FAIL err_first_cycle: got trans=%b ack=%b expected 00/0", HTRANS, d_ack);
    end
    step();
    HRESP = 0;
    n_checks++;
    if ({d_ack, d_err, i_ack, d_rdata} !== {1'b1, EXP_ERR, 1'b0, 32'h55}) begin
      n_fail++; $display("FAIL err_ack: got ack=%b err=%b iack=%b rdata=%h expected 1/%b/0/55",
                         d_ack, d_err, i_ack, d_rdata, EXP_ERR);
    end
`ifdef CORE_AHB_ERR_EN
    n_checks++;
    if (err_addr !== 32'h4000) begin
      n_fail++; $display("FAIL err_addr: got %h expected 00004000", err_addr);
    end
`endif
    d_req = 0;
    step();
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_we = 1; d_addr = 32'h5000; d_size = 2'b10; d_wdata = 32'h1234_5678; HREADY = 1;
    step();
    step();
    HREADY = 0;
    #3;
    reset = 1; d_req = 0; d_we = 0;
    #1;
    n_checks++;
    if ({HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA} !== {32'h0, 2'b00, 1'b0, 3'b010, 4'b0011, 32'h0}) begin
      n_fail++; $display("FAIL reset_mid_async: got addr=%h trans=%b wr=%b size=%b prot=%b wdata=%h",
                         HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA);
    end
    @(posedge clk); #1;
    reset = 0; HREADY = 1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if ({i_ack, d_ack, HTRANS} !== 4'b0000) begin
        n_fail++; $display("FAIL reset_mid_noack: got ack=%b%b trans=%b expected 00/00", i_ack, d_ack, HTRANS);
      end
    end
    i_req = 1; i_addr = 32'h300; HRDATA = 32'h0000_0013;
    step();
    n_checks++;
    if ({HTRANS, HADDR} !== {2'b10, 32'h300}) begin
      n_fail++; $display("FAIL reset_mid_restart: got trans=%b addr=%h expected 10/300", HTRANS, HADDR);
    end
    step(); step();
    n_checks++;
    if ({i_ack, i_rdata} !== {1'b1, 32'h13}) begin
      n_fail++; $display("FAIL reset_mid_ack: got ack=%b rdata=%h expected 1/13", i_ack, i_rdata);
    end
    i_req = 0;
    step();
  endtask

  // Random requests against a bus-phase model and a grant-order queue.
  task automatic test_random();
    bit          order[$];
    bit          last_d, addr_ph, data_ph, ack_due;
    int          mode, budget;
    logic [31:0] exp_rd, exp_addr;
    logic        exp_wr;
    logic [2:0]  exp_sz;
    logic [3:0]  exp_pr;
    logic [1:0]  tr;
    reset = 1;
    idle_inputs();
    step(); step();
    reset = 0;
    last_d = 0;
    for (int it = 0; it < 40; it++) begin
      mode    = $urandom_range(0, 2);
      i_addr  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      d_addr  = $urandom;
      d_we    = $urandom_range(0, 1);
      d_size  = $urandom_range(0, 3);
      d_wdata = $urandom;
      order.delete();
      if (mode == 0) order.push_back(1'b0);
      else if (mode == 1) order.push_back(1'b1);
      else if (last_d) begin order.push_back(1'b0); order.push_back(1'b1); end
      else begin order.push_back(1'b1); order.push_back(1'b0); end
      i_req = (mode != 1);
      d_req = (mode != 0);
      addr_ph = 0; data_ph = 0; ack_due = 0; budget = 0;
      while (order.size() > 0 && budget < 80) begin
        n_checks++;
        if (ack_due) begin
          if ({i_ack, d_ack, i_err, d_err} !== {!order[0], order[0], 2'b00} ||
              (order[0] ? d_rdata : i_rdata) !== exp_rd) begin
            n_fail++; $display("FAIL rand_ack it%0d: got i/d=%b%b err=%b%b rdata=%h expected %b%b rdata=%h",
                               it, i_ack, d_ack, i_err, d_err, order[0] ? d_rdata : i_rdata,
                               !order[0], order[0], exp_rd);
          end
          if (order[0]) d_req = 0; else i_req = 0;
          last_d = order[0];
          void'(order.pop_front());
          ack_due = 0;
        end else if (i_ack || d_ack) begin
          n_fail++; $display("FAIL rand_spurious_ack it%0d: got i/d=%b%b expected 00", it, i_ack, d_ack);
        end
        if (order.size() > 0 && HTRANS == 2'b10) begin
          if (order[0]) begin
            exp_addr = d_addr; exp_wr = d_we; exp_pr = 4'b0011;
            exp_sz = (d_size == 2'b11) ? 3'b010 : {1'b0, d_size};
          end else begin
            exp_addr = i_addr; exp_wr = 1'b0; exp_pr = 4'b0010; exp_sz = 3'b010;
          end
          n_checks++;
          if ({HADDR, HWRITE, HSIZE, HPROT} !== {exp_addr, exp_wr, exp_sz, exp_pr}) begin
            n_fail++; $display("FAIL rand_addr_phase it%0d: got %h/%b/%b/%b expected %h/%b/%b/%b",
                               it, HADDR, HWRITE, HSIZE, HPROT, exp_addr, exp_wr, exp_sz, exp_pr);
          end
          addr_ph = 1;
        end
        if (data_ph) begin
          n_checks++;
          if (HTRANS !== 2'b00 || (order[0] && d_we && HWDATA !== lanes(d_size, d_wdata))) begin
            n_fail++; $display("FAIL rand_data_phase it%0d: got trans=%b hwdata=%h expected 00/%h",
                               it, HTRANS, HWDATA, lanes(d_size, d_wdata));
          end
        end
        HREADY = ($urandom_range(0, 2) != 0);
        HRDATA = $urandom;
        tr = HTRANS;
        @(posedge clk);
        if (data_ph && HREADY) begin
          ack_due = 1; exp_rd = HRDATA; data_ph = 0;
        end
        if (addr_ph && tr == 2'b10 && HREADY) begin
          data_ph = 1; addr_ph = 0;
        end
        #1;
        budget++;
      end
      if (budget >= 80) begin
        n_checks++; n_fail++;
        $display("FAIL rand_timeout it%0d: got %0d pending acks expected 0", it, order.size());
        i_req = 0; d_req = 0;
        reset = 1; step(); reset = 0; last_d = 0;
      end
      HREADY = 1;
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_fetch();
    test_byte_store();
    test_contention();
    test_error();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
